// File: rtl/nespc_pkg.sv
// Shared definitions for the NES CPU bus front end: FSM encoding and the
// register window decoded into REG_HIT.
package nespc_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_LOW    = 2'd1,
        S_HIGH   = 2'd2,
        S_STROBE = 2'd3
    } state_e;

    localparam logic [15:0] REG_BASE = 16'h4020;
    localparam logic [15:0] REG_END  = 16'h40FF;

    function automatic logic is_reg(input logic [15:0] a);
        return (a >= REG_BASE) && (a <= REG_END);
    endfunction

endpackage

// File: rtl/cpu_bus_sync_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset
// and a per-bit reset value.
module sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpu_bus_sync.sv
// NES CPU bus synchronizer: one read/write strobe per qualified M2 cycle.
// Optional M2 loss watchdog is built when NESPC_M2_WDOG_EN is defined.
//
// Handshake: BUS_WR/BUS_RD are single-cycle valid pulses with no ready; BUS_A,
// BUS_D and REG_HIT are valid in the strobe cycle and held until the next one.
module cpu_bus_sync
    import nespc_pkg::*;
#(
    parameter int          M2_MIN_HIGH = 3,
    parameter logic [15:0] WDOG_LIMIT  = 16'hFFFF
) (
    input  logic        SYSCLK,
    input  logic        nRST,
    input  logic        M2,
    input  logic        nROMSEL,
    input  logic        CPU_RW,
    input  logic [14:0] CPU_A,
    input  logic [7:0]  CPU_D,
    output logic [15:0] BUS_A,
    output logic [7:0]  BUS_D,
    output logic        BUS_WR,
    output logic        BUS_RD,
    output logic        REG_HIT,
    output logic        GLITCH,
    output logic        M2_LOST,
    output state_e      dbg_state
);

    localparam int            HW    = $clog2(M2_MIN_HIGH) + 1;
    localparam logic [HW-1:0] HMAX  = '1;
    localparam logic [HW-1:0] MIN_H = HW'(M2_MIN_HIGH);

    logic [25:0]   bus_s;
    logic          m2_s, rom_s, rw_s, m2_d;
    logic [14:0]   a_s;
    logic [7:0]    d_s;
    logic          m2_fall, strobe_go;
    state_e        state;
    logic [HW-1:0] hcnt;
    logic [15:0]   cap_a;
    logic [7:0]    cap_d;
    logic          cap_rw;

    // M2 resets high so a phi2 pulse already in progress at reset release is
    // skipped by S_WAIT instead of being seen as a fresh rising edge.
    sync2 #(.W(26), .RST_VAL(26'h200_0000)) u_sync (
        .clk   (SYSCLK),
        .rst_n (nRST),
        .d     ({M2, nROMSEL, CPU_RW, CPU_A, CPU_D}),
        .q     (bus_s)
    );

    assign m2_s  = bus_s[25];
    assign rom_s = bus_s[24];
    assign rw_s  = bus_s[23];
    assign a_s   = bus_s[22:8];
    assign d_s   = bus_s[7:0];

    always_ff @(posedge SYSCLK or negedge nRST) begin
        if (!nRST) m2_d <= 1'b1;
        else       m2_d <= m2_s;
    end

    assign m2_fall   = m2_d & ~m2_s;
    assign strobe_go = (state == S_HIGH) && m2_fall && (hcnt >= MIN_H);
    assign dbg_state = state;

    always_ff @(posedge SYSCLK or negedge nRST) begin
        if (!nRST) begin
            state   <= S_WAIT;
            hcnt    <= '0;
            cap_a   <= '0;
            cap_d   <= '0;
            cap_rw  <= 1'b1;
            BUS_A   <= '0;
            BUS_D   <= '0;
            BUS_WR  <= 1'b0;
            BUS_RD  <= 1'b0;
            REG_HIT <= 1'b0;
            GLITCH  <= 1'b0;
        end else begin
            BUS_WR <= 1'b0;
            BUS_RD <= 1'b0;
            GLITCH <= 1'b0;
            case (state)
                S_WAIT: if (!m2_s) state <= S_LOW;
                S_LOW: begin
                    if (m2_s) begin
                        state <= S_HIGH;
                        hcnt  <= HW'(1);
                    end
                end
                S_HIGH: begin
                    if (m2_s) begin
                        if (hcnt != HMAX) hcnt <= hcnt + HW'(1);
                        cap_a  <= {~rom_s, a_s};
                        cap_d  <= d_s;
                        cap_rw <= rw_s;
                    end else if (strobe_go) begin
                        state   <= S_STROBE;
                        BUS_WR  <= ~cap_rw;
                        BUS_RD  <= cap_rw;
                        BUS_A   <= cap_a;
                        BUS_D   <= cap_d;
                        REG_HIT <= is_reg(cap_a);
                    end else begin
                        GLITCH <= 1'b1;
                        state  <= S_LOW;
                    end
                end
                S_STROBE: state <= S_LOW;
                default:  state <= S_WAIT;
            endcase
        end
    end

`ifdef NESPC_M2_WDOG_EN
    logic [15:0] wdog_cnt;
    logic        m2_lost_q;

    // Cleared on the edge that raises the strobe, so the count is measured
    // from the strobe cycle itself.
    always_ff @(posedge SYSCLK or negedge nRST) begin
        if (!nRST) begin
            wdog_cnt  <= '0;
            m2_lost_q <= 1'b0;
        end else if (strobe_go) begin
            wdog_cnt  <= '0;
            m2_lost_q <= 1'b0;
        end else if (wdog_cnt != WDOG_LIMIT) begin
            wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_cnt + 16'd1 == WDOG_LIMIT) m2_lost_q <= 1'b1;
        end
    end

    assign M2_LOST = m2_lost_q;
`else
    assign M2_LOST = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_sync.sv
// Directed bench for cpu_bus_sync: scoreboard queue of expected strobes with a
// separate negedge monitor.
module tb_cpu_bus_sync;
    import nespc_pkg::*;

    logic        SYSCLK = 1'b0;
    logic        nRST = 1'b0;
    logic        M2 = 1'b0, nROMSEL = 1'b1, CPU_RW = 1'b1;
    logic [14:0] CPU_A = '0;
    logic [7:0]  CPU_D = '0;
    logic [15:0] BUS_A;
    logic [7:0]  BUS_D;
    logic        BUS_WR, BUS_RD, REG_HIT, GLITCH, M2_LOST;
    state_e      dbg_state;

    // {wr, rd, bus_a, bus_d, reg_hit}
    logic [26:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int glitch_cnt = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;

    cpu_bus_sync #(.M2_MIN_HIGH(3), .WDOG_LIMIT(16'd50)) dut (
        .SYSCLK(SYSCLK), .nRST(nRST), .M2(M2), .nROMSEL(nROMSEL), .CPU_RW(CPU_RW),
        .CPU_A(CPU_A), .CPU_D(CPU_D), .BUS_A(BUS_A), .BUS_D(BUS_D), .BUS_WR(BUS_WR),
        .BUS_RD(BUS_RD), .REG_HIT(REG_HIT), .GLITCH(GLITCH), .M2_LOST(M2_LOST),
        .dbg_state(dbg_state)
    );

    // ---- clock / reset ----
    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    // ---- driver tasks ----
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge SYSCLK);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Full CPU cycle: hold old bus 2 cycles into the low phase, then present
    // the new one, raise M2 for hi cycles and drop it.
    task automatic cpu_cycle(input logic rw, input logic rom, input logic [14:0] a,
                             input logic [7:0] d, input int hi, input int lo,
                             input bit expect_strobe);
        logic [15:0] a16;
        a16 = {~rom, a};
        if (expect_strobe)
            exp_q.push_back({~rw, rw, a16, d, (a16 >= 16'h4020) && (a16 <= 16'h40FF)});
        M2 = 1'b0;
        wait_cyc(2);
        CPU_RW = rw; nROMSEL = rom; CPU_A = a; CPU_D = d;
        wait_cyc(lo - 2);
        M2 = 1'b1;
        wait_cyc(hi);
        M2 = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge SYSCLK);
        #2;
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---- scoreboard monitor ----
    always @(negedge SYSCLK) begin
        logic [26:0] got, exp;
        if (nRST && GLITCH) glitch_cnt++;
        if (nRST && (BUS_WR || BUS_RD)) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            got = {BUS_WR, BUS_RD, BUS_A, BUS_D, REG_HIT};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected strobe: got wr=%0b rd=%0b a=%h d=%h hit=%0b",
                         BUS_WR, BUS_RD, BUS_A, BUS_D, REG_HIT);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL strobe %0d: got wr=%0b rd=%0b a=%h d=%h hit=%0b, expected wr=%0b rd=%0b a=%h d=%h hit=%0b",
                             strobe_cnt, got[26], got[25], got[24:9], got[8:1], got[0],
                             exp[26], exp[25], exp[24:9], exp[8:1], exp[0]);
                end
            end
`ifdef NESPC_M2_WDOG_EN
            check("m2_lost_clear_at_strobe", {31'd0, M2_LOST}, 0);
`endif
        end
    end

    // ---- stimulus ----
    initial begin
        int s0, g0;
        #1;
        check("reset_bus_a", {16'd0, BUS_A}, 0);
        check("reset_strobes", {28'd0, BUS_D == 8'd0, BUS_WR, BUS_RD, REG_HIT}, 32'h8);
        check("reset_glitch_lost", {30'd0, GLITCH, M2_LOST}, 0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
        wait_cyc(3);
        nRST = 1'b1;
        wait_cyc(4);

        // write into the register window
        cpu_cycle(1'b0, 1'b1, 15'h4030, 8'hA5, 10, 8, 1'b1);
        drain("write_drain");
        // read from ROM space
        cpu_cycle(1'b1, 1'b0, 15'h7FFC, 8'h00, 8, 8, 1'b1);
        drain("read_drain");
        check("read_bus_a", {16'd0, BUS_A}, 32'h0000FFFC);

        // glitch: two synchronized high samples, below the minimum of three
        s0 = strobe_cnt; g0 = glitch_cnt;
        cpu_cycle(1'b0, 1'b1, 15'h1234, 8'h77, 2, 8, 1'b0);
        wait_cyc(10);
        check("glitch_count", glitch_cnt, g0 + 1);
        check("glitch_no_strobe", strobe_cnt, s0);
        check("glitch_bus_a_held", {16'd0, BUS_A}, 32'h0000FFFC);

        // reset in the middle of a high phase
        s0 = strobe_cnt;
        M2 = 1'b0;
        wait_cyc(2);
        CPU_RW = 1'b0; nROMSEL = 1'b1; CPU_A = 15'h4025; CPU_D = 8'h3C;
        wait_cyc(2);
        M2 = 1'b1;
        wait_cyc(4);
        nRST = 1'b0;
        #1;
        check("midreset_bus_a", {16'd0, BUS_A}, 0);
        check("midreset_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
        wait_cyc(1);
        nRST = 1'b1;
        wait_cyc(6);
        M2 = 1'b0;
        wait_cyc(10);
        check("midreset_no_strobe", strobe_cnt, s0);
        cpu_cycle(1'b0, 1'b1, 15'h4021, 8'h5A, 8, 8, 1'b1);
        drain("post_reset_drain");
        check("post_reset_strobe", strobe_cnt, s0 + 1);

        // 100 back-to-back cycles, 8 high / 8 low
        s0 = strobe_cnt;
        for (int i = 0; i < 100; i++)
            cpu_cycle(i[1], i[2], 15'h4000 + 15'(i * 3), 8'(i * 7 + 1), 8, 8, 1'b1);
        drain("b2b_drain");
        check("b2b_count", strobe_cnt, s0 + 100);

`ifdef NESPC_M2_WDOG_EN
        begin
            int seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge SYSCLK);
                if (M2_LOST) seen = 1;
            end
            check("wdog_set", seen, 1);
            check("wdog_delay", cyc - last_strobe_cyc, 50);
            wait_cyc(20);
            check("wdog_sticky", {31'd0, M2_LOST}, 1);
            cpu_cycle(1'b1, 1'b1, 15'h4040, 8'h00, 8, 8, 1'b1);
            drain("wdog_resume_drain");
            check("wdog_cleared", {31'd0, M2_LOST}, 0);
        end
`else
        wait_cyc(80);
        check("m2_lost_tied_low", {31'd0, M2_LOST}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
